// File: rtl/duty_pkg.sv
`default_nettype none
// Shared types and constants for the duty sequencer block.
package duty_pkg;

  localparam int DUTY_W = 12;
  localparam int CNT_W  = 16;

  localparam logic [DUTY_W-1:0] DUTY_MAX_DEFAULT = 12'h1F4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GR_NONE = 2'd0,
    GR_LINK = 2'd1,
    GR_UP   = 2'd2,
    GR_DN   = 2'd3
  } grant_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] limit
  );
    return (duty > limit) ? limit : duty;
  endfunction

endpackage
`default_nettype wire

// File: rtl/holdoff_timer.sv
`default_nettype none
// Down-counter that paces commands: loads on request, decrements while enabled,
// and reports when it has run out.
module holdoff_timer
  import duty_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOAD_VALUE = 16'd999
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VALUE;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/duty_sequencer.sv
`default_nettype none
// Arbitrates button step requests and link absolute-duty requests into paced,
// single-cycle commands for the downstream duty-adjust stage.
module duty_sequencer
  import duty_pkg::*;
#(
  parameter int unsigned       HOLDOFF_CYCLES = 1000,
  parameter logic [DUTY_W-1:0] DUTY_MAX       = DUTY_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              link_valid,
  input  logic [DUTY_W-1:0] link_duty,
  output logic              link_ack,
  output logic              l_rdy,
  output logic              l_up_down,
  output logic              data_start,
  output logic [DUTY_W-1:0] l_data,
  output logic              busy,
  output logic              clamp_err
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t            state, state_nxt;
  grant_t            grant, grant_nxt;
  logic              up_pend, dn_pend, up_pend_nxt, dn_pend_nxt;
  logic              take, timer_zero, in_issue, in_hold, link_sel;
  logic [DUTY_W-1:0] data_q;
  logic              dir_q, clamp_q;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (link_valid || up_pend || dn_pend) begin
          state_nxt = ST_ISSUE;
          take      = 1'b1;
          if (link_valid)   grant_nxt = GR_LINK;
          else if (up_pend) grant_nxt = GR_UP;
          else              grant_nxt = GR_DN;
        end
      end
      ST_ISSUE: state_nxt = ST_HOLD;
      ST_HOLD:  if (timer_zero) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The granted flag is consumed first so a button pulse on the grant edge still registers.
  always_comb begin
    up_pend_nxt = up_pend;
    dn_pend_nxt = dn_pend;
    if (take && (grant_nxt == GR_UP)) up_pend_nxt = 1'b0;
    if (take && (grant_nxt == GR_DN)) dn_pend_nxt = 1'b0;
    if (btn_up && !btn_down) begin
      up_pend_nxt = 1'b1;
      dn_pend_nxt = 1'b0;
    end else if (btn_down && !btn_up) begin
      up_pend_nxt = 1'b0;
      dn_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= GR_NONE;
      up_pend <= 1'b0;
      dn_pend <= 1'b0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      up_pend <= up_pend_nxt;
      dn_pend <= dn_pend_nxt;
      if (take) begin
        if (grant_nxt == GR_LINK) begin
          data_q  <= clamp_duty(link_duty, DUTY_MAX);
          clamp_q <= (link_duty > DUTY_MAX);
        end else begin
          dir_q   <= (grant_nxt == GR_UP);
          clamp_q <= 1'b0;
        end
      end
    end
  end

  assign in_issue = (state == ST_ISSUE);
  assign in_hold  = (state == ST_HOLD);
  assign link_sel = (grant == GR_LINK);

  holdoff_timer #(
    .LOAD_VALUE(HOLD_LOAD)
  ) u_holdoff_timer (
    .clk  (clk),
    .rst  (rst),
    .load (in_issue),
    .count(in_hold),
    .zero (timer_zero)
  );

  assign l_rdy      = in_issue & ~link_sel;
  assign data_start = in_issue & link_sel;
  assign link_ack   = in_issue & link_sel;
  assign clamp_err  = in_issue & link_sel & clamp_q;
  assign l_up_down  = dir_q;
  assign l_data     = data_q;
  assign busy       = (state != ST_IDLE);

endmodule
`default_nettype wire
